// File: rtl/vga_scan_generator.sv
// Raster timing source: free-running h/v counters, per-axis phase FSMs,
// coordinate/strobe outputs, and a pix_en-gated align pipe that keeps
// hsync/vsync in step with the coloured pixel returned by game logic.
module vga_scan_generator #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1,
  parameter bit          SYNC_NEG   = 1'b1,
  parameter logic [5:0]  FG_COLOR   = 6'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       pixel_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       line_end,
  output logic       frame_end,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = 3 * PIPE_DELAY;

  // Last count of each phase; the phase changes on the following enabled clock.
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_LAST   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_LAST   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  phase_t        h_state, h_state_nxt;
  phase_t        v_state, v_state_nxt;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_act, v_act;
  logic          raw_hsync, raw_vsync;
  logic [PW-1:0] pipe;
  logic [PW+2:0] pipe_shift;
  logic [2:0]    pipe_tail;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Horizontal/vertical position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Phase state registers for both axes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // Phase next-state: horizontal steps per enabled clock, vertical per line end.
  always_comb begin
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (pix_en) begin
      unique case (h_state)
        PH_ACTIVE: if (h_cnt == H_ACT_LAST)  h_state_nxt = PH_FRONT;
        PH_FRONT:  if (h_cnt == H_FP_LAST)   h_state_nxt = PH_SYNC;
        PH_SYNC:   if (h_cnt == H_SYNC_LAST) h_state_nxt = PH_BACK;
        PH_BACK:   if (h_wrap)               h_state_nxt = PH_ACTIVE;
        default:                             h_state_nxt = PH_ACTIVE;
      endcase
      if (h_wrap) begin
        unique case (v_state)
          PH_ACTIVE: if (v_cnt == V_ACT_LAST)  v_state_nxt = PH_FRONT;
          PH_FRONT:  if (v_cnt == V_FP_LAST)   v_state_nxt = PH_SYNC;
          PH_SYNC:   if (v_cnt == V_SYNC_LAST) v_state_nxt = PH_BACK;
          PH_BACK:   if (v_wrap)               v_state_nxt = PH_ACTIVE;
          default:                             v_state_nxt = PH_ACTIVE;
        endcase
      end
    end
  end

  // Coordinates and strobes come straight off the counter/phase registers.
  assign h_act     = (h_state == PH_ACTIVE);
  assign v_act     = (v_state == PH_ACTIVE);
  assign raw_hsync = (h_state == PH_SYNC);
  assign raw_vsync = (v_state == PH_SYNC);
  assign x         = h_act ? h_cnt : '0;
  assign y         = v_act ? v_cnt[8:0] : '0;
  assign active    = h_act & v_act;
  assign line_end  = pix_en & h_wrap;
  assign frame_end = pix_en & h_wrap & v_wrap;

  // Delay line matching the pixel source latency; shares pix_en so stalls stay aligned.
  assign pipe_shift = {pipe, raw_hsync, raw_vsync, active};
  assign pipe_tail  = pipe[PW-1 -: 3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (pix_en) begin
      pipe <= pipe_shift[PW-1:0];
    end
  end

  // Output stage: colour the returned pixel, blank outside active, apply sync polarity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= SYNC_NEG;
      vsync <= SYNC_NEG;
    end else if (pix_en) begin
      rgb   <= (pipe_tail[0] & pixel_in) ? FG_COLOR : 6'h00;
      hsync <= pipe_tail[2] ^ SYNC_NEG;
      vsync <= pipe_tail[1] ^ SYNC_NEG;
    end
  end

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: a default-timing instance plus a tiny-raster
// instance (so frame wrap and vertical phases are reachable), driven in lockstep.
module tb_vga_scan_generator;

  localparam int NI = 2;
  localparam int HA [NI] = '{640, 8};
  localparam int HF [NI] = '{16, 2};
  localparam int HS [NI] = '{96, 3};
  localparam int HB [NI] = '{48, 2};
  localparam int VA [NI] = '{480, 5};
  localparam int VF [NI] = '{10, 1};
  localparam int VS [NI] = '{2, 2};
  localparam int VB [NI] = '{33, 2};
  localparam logic [7:0] IDLE_PINS = 8'h03;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic       pix_in [NI];
  logic [9:0] x_o    [NI];
  logic [8:0] y_o    [NI];
  logic       act_o  [NI];
  logic       le_o   [NI];
  logic       fe_o   [NI];
  logic       hs_o   [NI];
  logic       vs_o   [NI];
  logic [5:0] rgb_o  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vga_scan_generator #(
      .H_ACTIVE(HA[gi]), .H_FP(HF[gi]), .H_SYNC(HS[gi]), .H_BP(HB[gi]),
      .V_ACTIVE(VA[gi]), .V_FP(VF[gi]), .V_SYNC(VS[gi]), .V_BP(VB[gi]),
      .PIPE_DELAY(1), .SYNC_NEG(1'b1), .FG_COLOR(6'h3F)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_in(pix_in[gi]),
      .x(x_o[gi]), .y(y_o[gi]), .active(act_o[gi]), .line_end(le_o[gi]),
      .frame_end(fe_o[gi]), .hsync(hs_o[gi]), .vsync(vs_o[gi]), .rgb(rgb_o[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_bad;
  logic [15:0] exp_q [$];
  int          m_h [NI];
  int          m_v [NI];
  logic [7:0]  cur_exp [NI];
  logic        pend_b [NI];
  bit          pat_one;
  int          samp, cnt_rgb, cnt_hlow, cnt_le, cnt_fe, first_rgb, first_hlow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {rgb, hsync, vsync} for a coordinate whose returned pixel is b.
  function automatic logic [7:0] exp_pins(int i, int h, int v, logic b);
    logic act, rh, rv;
    logic [5:0] c;
    act = (h < HA[i]) && (v < VA[i]);
    rh  = (h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]);
    rv  = (v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]);
    c   = (act && b) ? 6'h3F : 6'h00;
    return {c, ~rh, ~rv};
  endfunction

  // One clock: drive, check everything, push the scoreboard, advance the model.
  task automatic cycle(input bit en);
    logic [15:0] pv;
    logic        b;
    int          ht, vt;
    @(negedge clk);
    pix_en = en;
    for (int i = 0; i < NI; i++) pix_in[i] = pend_b[i];
    #1;
    pv = '0;
    for (int i = 0; i < NI; i++) begin
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      check($sformatf("x%0d", i), 32'(x_o[i]), (m_h[i] < HA[i]) ? m_h[i] : 0);
      check($sformatf("y%0d", i), 32'(y_o[i]), (m_v[i] < VA[i]) ? m_v[i] : 0);
      check($sformatf("active%0d", i), 32'(act_o[i]), 32'((m_h[i] < HA[i]) && (m_v[i] < VA[i])));
      check($sformatf("line_end%0d", i), 32'(le_o[i]), 32'(en && (m_h[i] == ht - 1)));
      check($sformatf("frame_end%0d", i), 32'(fe_o[i]),
            32'(en && (m_h[i] == ht - 1) && (m_v[i] == vt - 1)));
      check($sformatf("pins%0d", i), 32'({rgb_o[i], hs_o[i], vs_o[i]}), 32'(cur_exp[i]));
      if (en) begin
        b = pat_one ? 1'b1 : 1'($urandom_range(0, 1));
        pv[i*8 +: 8] = exp_pins(i, m_h[i], m_v[i], b);
        pend_b[i] = b;
      end
    end
    if (rgb_o[0] == 6'h3F) begin
      cnt_rgb++;
      if (first_rgb < 0) first_rgb = samp;
    end
    if (hs_o[0] == 1'b0) begin
      cnt_hlow++;
      if (first_hlow < 0) first_hlow = samp;
    end
    if (le_o[0]) cnt_le++;
    if (fe_o[1]) cnt_fe++;
    samp++;
    if (en) exp_q.push_back(pv);
    @(posedge clk);
    if (en) begin
      for (int i = 0; i < NI; i++) begin
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        if (m_h[i] == ht - 1) begin
          m_h[i] = 0;
          m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
        end else begin
          m_h[i] = m_h[i] + 1;
        end
      end
      if (exp_q.size() >= 2) begin
        pv = exp_q.pop_front();
        for (int i = 0; i < NI; i++) cur_exp[i] = pv[i*8 +: 8];
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      m_h[i]     = 0;
      m_v[i]     = 0;
      cur_exp[i] = IDLE_PINS;
      pend_b[i]  = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic clear_meas();
    samp = 0; cnt_rgb = 0; cnt_hlow = 0; cnt_le = 0; cnt_fe = 0;
    first_rgb = -1; first_hlow = -1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    pix_en = 1'b0;
    for (int i = 0; i < NI; i++) pix_in[i] = 1'b0;
    pat_one = 1'b1;

    // Power-on reset, then one full line with pixel_in held high.
    do_reset(3);
    clear_meas();
    for (int k = 0; k < 800; k++) cycle(1'b1);
    check("rgb_high_count", 32'(cnt_rgb), 32'd640);
    check("rgb_first_high", 32'(first_rgb), 32'd2);
    check("hsync_low_count", 32'(cnt_hlow), 32'd96);
    check("hsync_fall", 32'(first_hlow), 32'd658);

    // Two more lines; small raster wraps its 150-clock frame many times.
    for (int k = 0; k < 1600; k++) cycle(1'b1);
    check("line_end_count", 32'(cnt_le), 32'd3);
    check("frame_end_count", 32'(cnt_fe), 32'd16);

    // Alternating enable with random pixels: periods double, outputs hold.
    pat_one = 1'b0;
    clear_meas();
    for (int k = 0; k < 3200; k++) cycle((k % 2) == 0);
    check("line_end_count_stall", 32'(cnt_le), 32'd2);

    // Random enable pattern.
    for (int k = 0; k < 2000; k++) cycle($urandom_range(0, 3) != 0);

    // Mid-frame reset at h=300, then normal restart.
    for (int k = 0; k < 800 && m_h[0] != 300; k++) cycle(1'b1);
    #1;
    check("x_before_reset", 32'(x_o[0]), 32'd300);
    do_reset(1);
    for (int k = 0; k < 1000; k++) cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
